// File: rtl/RS5_pkg.sv
// Shared types and decode boundaries for the two-master memory arbiter.
// Owner tracking, slave selection and the address-nibble decode limits live here.
package RS5_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // Values double as bit positions in the decoder's one-hot select.
  typedef enum logic [1:0] {
    SL_RAM  = 2'd0,
    SL_RTC  = 2'd1,
    SL_PLIC = 2'd2,
    SL_TB   = 2'd3
  } slave_e;

  localparam logic [3:0] DEC_RTC_BASE  = 4'h2;
  localparam logic [3:0] DEC_PLIC_BASE = 4'h3;
  localparam logic [3:0] DEC_TB_BASE   = 4'h8;

  function automatic slave_e oh_to_slave(input logic [3:0] oh);
    case (oh)
      4'b0010: return SL_RTC;
      4'b0100: return SL_PLIC;
      4'b1000: return SL_TB;
      default: return SL_RAM;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both master ports, the shared slave bus and the slave read-data returns.
// The arbiter takes the slave modport; requesters/slaves drive through the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0_req_i,    m1_req_i;
  logic [3:0]        m0_we_i,     m1_we_i;
  logic [ADDR_W-1:0] m0_addr_i,   m1_addr_i;
  logic [31:0]       m0_wdata_i,  m1_wdata_i;
  logic              m0_gnt_o,    m1_gnt_o;
  logic [31:0]       m0_rdata_o,  m1_rdata_o;
  logic              m0_rvalid_o, m1_rvalid_o;
  logic              en_ram_o, en_rtc_o, en_plic_o, en_tb_o;
  logic [3:0]        we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;
  logic [31:0]       ram_rdata_i, rtc_rdata_i, plic_rdata_i, tb_rdata_i;

  modport slave (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_addr_i, m1_addr_i,
           m0_wdata_i, m1_wdata_i, ram_rdata_i, rtc_rdata_i, plic_rdata_i, tb_rdata_i,
    output m0_gnt_o, m1_gnt_o, m0_rdata_o, m1_rdata_o, m0_rvalid_o, m1_rvalid_o,
           en_ram_o, en_rtc_o, en_plic_o, en_tb_o, we_o, addr_o, wdata_o
  );

  modport master (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_addr_i, m1_addr_i,
           m0_wdata_i, m1_wdata_i, ram_rdata_i, rtc_rdata_i, plic_rdata_i, tb_rdata_i,
    input  m0_gnt_o, m1_gnt_o, m0_rdata_o, m1_rdata_o, m0_rvalid_o, m1_rvalid_o,
           en_ram_o, en_rtc_o, en_plic_o, en_tb_o, we_o, addr_o, wdata_o
  );
endinterface

// File: rtl/mem_decoder.sv
// Combinational address decode on the top nibble into a one-hot slave select.
// Zero latency, no flow control.
module mem_decoder
  import RS5_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [3:0]        o_sel_oh
);
  logic [3:0] w_msn;
  logic       w_unused;

  assign w_msn    = i_addr[ADDR_W-1 -: 4];
  assign w_unused = ^i_addr[ADDR_W-5:0];

  always_comb begin
    o_sel_oh = '0;
    if (w_msn < DEC_RTC_BASE)       o_sel_oh[SL_RAM]  = 1'b1;
    else if (w_msn < DEC_PLIC_BASE) o_sel_oh[SL_RTC]  = 1'b1;
    else if (w_msn < DEC_TB_BASE)   o_sel_oh[SL_PLIC] = 1'b1;
    else                            o_sel_oh[SL_TB]   = 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter with bounded hold onto a shared 4-slave bus; grant and bus are same-cycle.
// Read data returns one cycle after grant; a master waits (gnt low) while the other owns the bus.
module mem_arbiter
  import RS5_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int ADDR_W   = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);
  localparam int                HOLD_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  owner_e            r_owner, r_last, w_last_nxt, w_gnt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic              w_any, w_rd;
  logic [3:0]        w_sel_oh;
  logic              r_rsp_vld, r_rsp_m1;
  slave_e            r_rsp_sel;
  logic [31:0]       w_rsp_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= OWN_NONE;
      r_last     <= OWN_M1;
      r_hold_cnt <= '0;
    end else begin
      r_owner    <= w_gnt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Grant is masked during reset so a pending request cannot slip through.
  always_comb begin
    w_gnt = OWN_NONE;
    if (reset_n) begin
      if (r_owner == OWN_M0 && bus.m0_req_i)
        w_gnt = (bus.m1_req_i && r_hold_cnt >= HOLD_MAX) ? OWN_M1 : OWN_M0;
      else if (r_owner == OWN_M1 && bus.m1_req_i)
        w_gnt = (bus.m0_req_i && r_hold_cnt >= HOLD_MAX) ? OWN_M0 : OWN_M1;
      else if (bus.m0_req_i && bus.m1_req_i)
        w_gnt = (r_last == OWN_M0) ? OWN_M1 : OWN_M0;
      else if (bus.m0_req_i)
        w_gnt = OWN_M0;
      else if (bus.m1_req_i)
        w_gnt = OWN_M1;
    end
    w_last_nxt = (w_gnt == OWN_NONE) ? r_last : w_gnt;
    w_hold_nxt = '0;
    if (w_gnt != OWN_NONE && w_gnt == r_owner)
      w_hold_nxt = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
  end

  assign w_any        = (w_gnt != OWN_NONE);
  assign bus.m0_gnt_o = (w_gnt == OWN_M0);
  assign bus.m1_gnt_o = (w_gnt == OWN_M1);

  always_comb begin
    bus.we_o    = '0;
    bus.addr_o  = '0;
    bus.wdata_o = '0;
    if (w_gnt == OWN_M0) begin
      bus.we_o    = bus.m0_we_i;
      bus.addr_o  = bus.m0_addr_i;
      bus.wdata_o = bus.m0_wdata_i;
    end else if (w_gnt == OWN_M1) begin
      bus.we_o    = bus.m1_we_i;
      bus.addr_o  = bus.m1_addr_i;
      bus.wdata_o = bus.m1_wdata_i;
    end
  end

  mem_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .i_addr   (bus.addr_o),
    .o_sel_oh (w_sel_oh)
  );

  assign bus.en_ram_o  = w_any & w_sel_oh[SL_RAM];
  assign bus.en_rtc_o  = w_any & w_sel_oh[SL_RTC];
  assign bus.en_plic_o = w_any & w_sel_oh[SL_PLIC];
  assign bus.en_tb_o   = w_any & w_sel_oh[SL_TB];
  assign w_rd          = w_any && (bus.we_o == 4'h0);

  // Response state is independent of the current grant, so reads pipeline back to back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_vld <= 1'b0;
      r_rsp_m1  <= 1'b0;
      r_rsp_sel <= SL_RAM;
    end else begin
      r_rsp_vld <= w_rd;
      r_rsp_m1  <= (w_gnt == OWN_M1);
      r_rsp_sel <= oh_to_slave(w_sel_oh);
    end
  end

  always_comb begin
    case (r_rsp_sel)
      SL_RAM:  w_rsp_dat = bus.ram_rdata_i;
      SL_RTC:  w_rsp_dat = bus.rtc_rdata_i;
      SL_PLIC: w_rsp_dat = bus.plic_rdata_i;
      default: w_rsp_dat = bus.tb_rdata_i;
    endcase
  end

  assign bus.m0_rvalid_o = r_rsp_vld & ~r_rsp_m1;
  assign bus.m1_rvalid_o = r_rsp_vld &  r_rsp_m1;
  assign bus.m0_rdata_o  = bus.m0_rvalid_o ? w_rsp_dat : '0;
  assign bus.m1_rdata_o  = bus.m1_rvalid_o ? w_rsp_dat : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, decode, hold/rotation, read response routing.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] RAM_D  = 32'hDEAD_BEEF;
  localparam logic [31:0] RTC_D  = 32'h1111_2222;
  localparam logic [31:0] PLIC_D = 32'h3333_4444;
  localparam logic [31:0] TB_D   = 32'h5555_6666;

  mem_arbiter_if #(.ADDR_W(32)) bus_if ();

  mem_arbiter #(.MAX_HOLD(4), .ADDR_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  logic [3:0] en_vec;
  logic [1:0] gnt_vec;
  logic [1:0] rv_vec;
  assign en_vec  = {bus_if.en_ram_o, bus_if.en_rtc_o, bus_if.en_plic_o, bus_if.en_tb_o};
  assign gnt_vec = {bus_if.m0_gnt_o, bus_if.m1_gnt_o};
  assign rv_vec  = {bus_if.m0_rvalid_o, bus_if.m1_rvalid_o};

  task automatic idle();
    bus_if.m0_req_i = 1'b0;  bus_if.m1_req_i = 1'b0;
    bus_if.m0_we_i = 4'h0;   bus_if.m1_we_i = 4'h0;
    bus_if.m0_addr_i = '0;   bus_if.m1_addr_i = '0;
    bus_if.m0_wdata_i = '0;  bus_if.m1_wdata_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    bus_if.ram_rdata_i = RAM_D;   bus_if.rtc_rdata_i = RTC_D;
    bus_if.plic_rdata_i = PLIC_D; bus_if.tb_rdata_i = TB_D;
    bus_if.m0_req_i = 1'b1;
    bus_if.m0_addr_i = 32'h0000_0100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (gnt_vec !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b expected 00", gnt_vec); end
    n_vec++; if (en_vec !== 4'b0000) begin n_err++; $display("FAIL reset_en: got %b expected 0000", en_vec); end
    n_vec++; if (bus_if.addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", bus_if.addr_o); end
    n_vec++; if (rv_vec !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b expected 00", rv_vec); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (gnt_vec !== 2'b10) begin n_err++; $display("FAIL reset_release_gnt: got %b expected 10", gnt_vec); end
    n_vec++; if (en_vec !== 4'b1000) begin n_err++; $display("FAIL reset_release_en: got %b expected 1000", en_vec); end
    step(); idle(); step(); step();
  endtask

  task automatic test_read_ram();
    bus_if.m0_req_i = 1'b1;
    bus_if.m0_addr_i = 32'h0000_0100;
    @(negedge clk);
    n_vec++; if (gnt_vec !== 2'b10) begin n_err++; $display("FAIL rd_ram_gnt: got %b expected 10", gnt_vec); end
    n_vec++; if (en_vec !== 4'b1000) begin n_err++; $display("FAIL rd_ram_en: got %b expected 1000", en_vec); end
    n_vec++; if (rv_vec !== 2'b00) begin n_err++; $display("FAIL rd_ram_rv0: got %b expected 00", rv_vec); end
    step(); idle();
    @(negedge clk);
    n_vec++; if (rv_vec !== 2'b10) begin n_err++; $display("FAIL rd_ram_rv1: got %b expected 10", rv_vec); end
    n_vec++; if (bus_if.m0_rdata_o !== RAM_D) begin n_err++; $display("FAIL rd_ram_data: got %h expected %h", bus_if.m0_rdata_o, RAM_D); end
    n_vec++; if (bus_if.m1_rdata_o !== 32'h0) begin n_err++; $display("FAIL rd_ram_m1data: got %h expected 0", bus_if.m1_rdata_o); end
    step();
    @(negedge clk);
    n_vec++; if (rv_vec !== 2'b00 || bus_if.m0_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL rd_ram_rv2: got rv %b data %h expected 00 / 0", rv_vec, bus_if.m0_rdata_o);
    end
    step();
  endtask

  task automatic test_decode();
    logic [31:0] addrs [4];
    logic [3:0]  exp_en [4];
    addrs[0] = 32'h2000_0000; exp_en[0] = 4'b0100;
    addrs[1] = 32'h3000_0004; exp_en[1] = 4'b0010;
    addrs[2] = 32'h8000_0000; exp_en[2] = 4'b0001;
    addrs[3] = 32'h1FFF_FFFC; exp_en[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      bus_if.m1_req_i = 1'b1;
      bus_if.m1_we_i = 4'h3;
      bus_if.m1_addr_i = addrs[i];
      bus_if.m1_wdata_i = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      n_vec++; if (en_vec !== exp_en[i]) begin n_err++; $display("FAIL decode_%0d: got %b expected %b", i, en_vec, exp_en[i]); end
      n_vec++; if (bus_if.addr_o !== addrs[i] || bus_if.we_o !== 4'h3 || bus_if.wdata_o !== 32'hA000_0000 + 32'(i)) begin
        n_err++; $display("FAIL decode_bus_%0d: got %h/%h/%h expected %h/3/%h", i, bus_if.addr_o, bus_if.we_o, bus_if.wdata_o, addrs[i], 32'hA000_0000 + 32'(i));
      end
      step(); idle();
      @(negedge clk);
      n_vec++; if (rv_vec !== 2'b00) begin n_err++; $display("FAIL write_no_rvalid_%0d: got %b expected 00", i, rv_vec); end
      n_vec++; if (en_vec !== 4'b0000 || bus_if.we_o !== 4'h0 || bus_if.addr_o !== 32'h0 || bus_if.wdata_o !== 32'h0) begin
        n_err++; $display("FAIL idle_bus_%0d: got en %b we %h addr %h wdata %h expected all 0", i, en_vec, bus_if.we_o, bus_if.addr_o, bus_if.wdata_o);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic exp0, prev0;
    apply_reset();
    bus_if.m0_req_i = 1'b1; bus_if.m0_addr_i = 32'h0000_0100;
    bus_if.m1_req_i = 1'b1; bus_if.m1_addr_i = 32'h8000_0010;
    prev0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp0 = (i < 4) || (i >= 8);
      @(negedge clk);
      n_vec++; if (gnt_vec !== {exp0, ~exp0}) begin n_err++; $display("FAIL rr_gnt_%0d: got %b expected %b", i, gnt_vec, {exp0, ~exp0}); end
      n_vec++; if (bus_if.addr_o !== (exp0 ? 32'h0000_0100 : 32'h8000_0010)) begin
        n_err++; $display("FAIL rr_addr_%0d: got %h expected %h", i, bus_if.addr_o, exp0 ? 32'h0000_0100 : 32'h8000_0010);
      end
      if (i > 0) begin
        n_vec++; if (rv_vec !== {prev0, ~prev0}) begin n_err++; $display("FAIL rr_rvalid_%0d: got %b expected %b", i, rv_vec, {prev0, ~prev0}); end
      end
      prev0 = exp0;
      step();
    end
    idle(); step(); step();
  endtask

  task automatic test_hold_m1();
    apply_reset();
    bus_if.m1_req_i = 1'b1; bus_if.m1_addr_i = 32'h0000_0040;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++; if (gnt_vec !== 2'b01) begin n_err++; $display("FAIL hold_m1_gnt_%0d: got %b expected 01", i, gnt_vec); end
      step();
    end
    bus_if.m0_req_i = 1'b1; bus_if.m0_addr_i = 32'h0000_0080;
    @(negedge clk);
    n_vec++; if (dut.r_hold_cnt !== 2'd3) begin n_err++; $display("FAIL hold_sat: got %0d expected 3", dut.r_hold_cnt); end
    n_vec++; if (gnt_vec !== 2'b10) begin n_err++; $display("FAIL hold_switch: got %b expected 10", gnt_vec); end
    step(); idle(); step(); step();
  endtask

  task automatic test_back_to_back();
    bus_if.m0_req_i = 1'b1; bus_if.m0_addr_i = 32'h2000_0000;
    @(negedge clk);
    n_vec++; if (gnt_vec !== 2'b10 || en_vec !== 4'b0100) begin n_err++; $display("FAIL b2b_c0: got gnt %b en %b expected 10 / 0100", gnt_vec, en_vec); end
    step(); idle();
    bus_if.m1_req_i = 1'b1; bus_if.m1_addr_i = 32'h3000_0000;
    @(negedge clk);
    n_vec++; if (gnt_vec !== 2'b01 || en_vec !== 4'b0010) begin n_err++; $display("FAIL b2b_c1_gnt: got gnt %b en %b expected 01 / 0010", gnt_vec, en_vec); end
    n_vec++; if (rv_vec !== 2'b10 || bus_if.m0_rdata_o !== RTC_D || bus_if.m1_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL b2b_c1_rsp: got rv %b d0 %h d1 %h expected 10 / %h / 0", rv_vec, bus_if.m0_rdata_o, bus_if.m1_rdata_o, RTC_D);
    end
    step(); idle();
    @(negedge clk);
    n_vec++; if (rv_vec !== 2'b01 || bus_if.m1_rdata_o !== PLIC_D || bus_if.m0_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL b2b_c2_rsp: got rv %b d0 %h d1 %h expected 01 / 0 / %h", rv_vec, bus_if.m0_rdata_o, bus_if.m1_rdata_o, PLIC_D);
    end
    step();
  endtask

  task automatic test_reset_after_read();
    bus_if.m1_req_i = 1'b1; bus_if.m1_addr_i = 32'h0000_0200;
    @(negedge clk);
    n_vec++; if (gnt_vec !== 2'b01) begin n_err++; $display("FAIL rar_gnt: got %b expected 01", gnt_vec); end
    @(posedge clk);
    #1 reset_n = 1'b0;
    idle();
    @(negedge clk);
    n_vec++; if (rv_vec !== 2'b00 || bus_if.m1_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL rar_rvalid: got rv %b d1 %h expected 00 / 0", rv_vec, bus_if.m1_rdata_o);
    end
    step(); step();
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (gnt_vec !== 2'b00 || en_vec !== 4'b0000 || rv_vec !== 2'b00 || bus_if.addr_o !== 32'h0) begin
      n_err++; $display("FAIL rar_quiet: got gnt %b en %b rv %b addr %h expected all 0", gnt_vec, en_vec, rv_vec, bus_if.addr_o);
    end
    step();
    bus_if.m0_req_i = 1'b1; bus_if.m0_addr_i = 32'h9000_0000;
    bus_if.m1_req_i = 1'b1; bus_if.m1_addr_i = 32'h0000_0300;
    @(negedge clk);
    n_vec++; if (gnt_vec !== 2'b10 || en_vec !== 4'b0001) begin n_err++; $display("FAIL rar_tie: got gnt %b en %b expected 10 / 0001", gnt_vec, en_vec); end
    step(); idle();
    @(negedge clk);
    n_vec++; if (rv_vec !== 2'b10 || bus_if.m0_rdata_o !== TB_D) begin
      n_err++; $display("FAIL rar_resp: got rv %b d0 %h expected 10 / %h", rv_vec, bus_if.m0_rdata_o, TB_D);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_read_ram();
    test_decode();
    test_round_robin();
    test_hold_m1();
    test_back_to_back();
    test_reset_after_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles for one master while the other master requests.
REQ-002 Parameter ADDR_W, default 32: address width of both masters and the shared bus.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 m0_req_i / m1_req_i  input  1  access request, master 0 = CPU data port, master 1 = accelerator.
REQ-006 mX_we_i  input  4  byte write enables; all zero means read.
REQ-007 mX_addr_i  input  ADDR_W  access address.
REQ-008 mX_wdata_i  input  32  write data.
REQ-009 mX_gnt_o  output  1  access accepted this cycle.
REQ-010 mX_rdata_o  output  32  read data, qualified by mX_rvalid_o.
REQ-011 mX_rvalid_o  output  1  read data valid, one cycle after the granted read.
REQ-012 en_ram_o / en_rtc_o / en_plic_o / en_tb_o  output  1  one-hot slave enables.
REQ-013 we_o / addr_o / wdata_o  output  4 / ADDR_W / 32  shared bus, driven from the granted master.
REQ-014 ram_rdata_i / rtc_rdata_i / plic_rdata_i / tb_rdata_i  input  32  slave read data, valid one cycle after enable.

Function
REQ-015 Grant is combinational from owner_q, hold_cnt_q, last_q and the requests; the shared bus carries the granted master's fields in the same cycle.
REQ-016 owner_q has states NONE, M0, M1; its next value is the master granted this cycle, or NONE when no request is present.
REQ-017 If the owner keeps requesting and the other master is idle, ownership is held with no limit.
REQ-018 If the owner keeps requesting and the other master requests, ownership is held while hold_cnt_q < MAX_HOLD-1; otherwise grant passes to the other master.
REQ-019 From NONE, or when the owner drops its request: a single requester is granted; with both requesting, the master that is not last_q is granted.
REQ-020 hold_cnt_q increments (saturating at MAX_HOLD-1) when the same master is granted on consecutive cycles, and clears to 0 on any change of grant or on an idle cycle.
REQ-021 last_q updates to the granted master on every grant cycle and holds its value on idle cycles.
REQ-022 At most one mX_gnt_o is high per cycle, and a master is only granted when it is requesting.
REQ-023 Decode uses addr[ADDR_W-1:ADDR_W-4]: < 0x2 selects RAM; < 0x3 selects RTC; < 0x8 selects PLIC; otherwise TB.
REQ-024 With no grant, all slave enables are 0, we_o is 0 and addr_o/wdata_o are 0.
REQ-025 A granted read registers the slave select and master id; the next cycle, rdata from that slave is routed to that master with mX_rvalid_o=1 for exactly one cycle.
REQ-026 Granted writes produce no rvalid.
REQ-027 A grant to the other master in the response cycle does not disturb the pending response, giving back-to-back reads full throughput.
REQ-028 Inactive mX_rdata_o is 0.

Reset
REQ-029 While reset_n=0: owner_q=NONE, last_q=M1 (so M0 wins the first tie), hold_cnt_q=0, registered response state cleared, and all mX_rvalid_o=0.
REQ-030 A request present during reset is granted combinationally only after reset_n deasserts; a read granted in the cycle before reset assertion produces no rvalid.

Structure
REQ-031 The owner enum, the slave-select enum and the decode boundary constants (0x2, 0x3, 0x8) are defined in RS5_pkg.
REQ-032 Address decode is one sub-module, mem_decoder: address in, one-hot slave select out, purely combinational.

Verification
REQ-033 M0 reads 0x00000100 with ram_rdata_i=0xDEADBEEF: m0_gnt_o=1 and en_ram_o=1 in cycle 0; m0_rdata_o=0xDEADBEEF and m0_rvalid_o=1 in cycle 1.
REQ-034 M0 and M1 request together straight after reset: M0 is granted first; with both held and MAX_HOLD=4, the grant pattern is M0 x4, M1 x4, M0 x4.
REQ-035 M1 alone requests for 10 cycles: m1_gnt_o=1 every cycle and hold_cnt saturates at 3 with no switch.
REQ-036 Decode: addresses 0x20000000, 0x30000004, 0x80000000 and 0x1FFFFFFC assert en_rtc_o, en_plic_o, en_tb_o and en_ram_o respectively.
REQ-037 M0 reads RTC in cycle 0 and M1 reads PLIC in cycle 1: m0 gets rtc_rdata_i in cycle 1, m1 gets plic_rdata_i in cycle 2, and no rvalid goes to the wrong master.
REQ-038 Reset asserted in the cycle after a granted read: no rvalid is produced, and all outputs are 0 until a request follows reset deassertion.
